// File: rtl/encoder_4x2_latched.sv
// Latched 4-to-2 priority encoder. Requests collect in a sticky pending vector;
// the highest pending index is presented on A/V and held until the consumer acks it.
module encoder_4x2_latched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:3] D,
  input  logic       E,
  input  logic       ack,
  output logic [1:0] A,
  output logic       V,
  output logic [0:3] pend,
  output logic       ovr
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_reg, state_next;
  logic [1:0] a_reg, a_next;
  logic       v_reg, v_next;
  logic [0:3] pend_reg, pend_next;
  logic       ovr_reg, ovr_next;
  logic [0:3] clr_bits, set_bits, hit_bits;
  logic [1:0] top_idx;

  // Per-bit pending logic: set wins over the handshake clear of the same bit,
  // and a bit being cleared in this cycle does not count as an overrun.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pend
      assign clr_bits[gi]  = (state_reg == HOLD) && ack && (a_reg == 2'(gi));
      assign set_bits[gi]  = E && D[gi];
      assign pend_next[gi] = (pend_reg[gi] && !clr_bits[gi]) || set_bits[gi];
      assign hit_bits[gi]  = set_bits[gi] && pend_reg[gi] && !clr_bits[gi];
    end
  endgenerate

  assign ovr_next = ovr_reg || (|hit_bits);

  // Later iterations overwrite earlier ones, so the highest set index wins.
  always_comb begin
    top_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (pend_reg[i]) top_idx = 2'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    v_next     = v_reg;
    case (state_reg)
      IDLE: begin
        v_next = 1'b0;
        if (|pend_reg) begin
          a_next     = top_idx;
          v_next     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          v_next     = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= 2'd0;
      v_reg     <= 1'b0;
      pend_reg  <= 4'b0000;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      v_reg     <= v_next;
      pend_reg  <= pend_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign A    = a_reg;
  assign V    = v_reg;
  assign pend = pend_reg;
  assign ovr  = ovr_reg;

endmodule

// File: tb/tb_encoder_4x2_latched.sv
// Directed scoreboard bench for encoder_4x2_latched: expected codes are queued when
// requests are driven and popped each time the encoder presents a code.
module tb_encoder_4x2_latched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:3] D;
  logic       E;
  logic       ack;
  logic [1:0] A;
  logic       V;
  logic [0:3] pend;
  logic       ovr;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  encoder_4x2_latched dut (
    .clk  (clk),
    .rst_n(rst_n),
    .D    (D),
    .E    (E),
    .ack  (ack),
    .A    (A),
    .V    (V),
    .pend (pend),
    .ovr  (ovr)
  );

  always #5 clk = ~clk;

  // Builds a request vector from a mask written D[3]..D[0], left to right.
  function automatic logic [0:3] mk(input logic [3:0] m);
    logic [0:3] r;
    for (int i = 0; i < 4; i++) r[i] = m[i];
    return r;
  endfunction

  function automatic logic [3:0] as_mask(input logic [0:3] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end else begin
      $display("ok   %s: %0h at %0t", tag, obs, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    D = mk(m);
    E = 1'b1;
    tick();
    D = 4'b0000;
    E = 1'b0;
  endtask

  task automatic wait_v();
    int n = 0;
    while (!V && n < 20) begin
      tick();
      n++;
    end
    check("v_wait", {7'd0, V}, 8'd1);
  endtask

  task automatic present();
    int e;
    wait_v();
    if (exp_q.size() == 0) begin
      check("sb_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check("code", {6'd0, A}, 8'(e));
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("v_drop", {7'd0, V}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    D     = 4'b0000;
    E     = 1'b0;
    ack   = 1'b0;
    #12;
    check("rst_pend", {4'd0, as_mask(pend)}, 8'd0);
    check("rst_vao", {5'd0, V, A}, 8'd0);
    check("rst_ovr", {7'd0, ovr}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request, latency and handshake
    pulse(4'b0100);
    check("s1_pend", {4'd0, as_mask(pend)}, 8'b0100);
    check("s1_v_e1", {7'd0, V}, 8'd0);
    exp_q.push_back(2);
    tick();
    check("s1_v_e2", {7'd0, V}, 8'd1);
    present();
    do_ack();
    check("s1_pend0", {4'd0, as_mask(pend)}, 8'd0);

    // Multiple requests served in descending order
    pulse(4'b1011);
    exp_q.push_back(3);
    exp_q.push_back(1);
    exp_q.push_back(0);
    for (int k = 0; k < 3; k++) begin
      present();
      do_ack();
    end
    check("s2_pend0", {4'd0, as_mask(pend)}, 8'd0);

    // Enable low masks all requests; ack in IDLE is ignored
    D   = 4'b1111;
    E   = 1'b0;
    ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("s3_pend", {4'd0, as_mask(pend)}, 8'd0);
      check("s3_v", {7'd0, V}, 8'd0);
    end
    D   = 4'b0000;
    ack = 1'b0;

    // Higher-priority arrival while holding code 1
    pulse(4'b0010);
    exp_q.push_back(1);
    present();
    pulse(4'b1000);
    exp_q.push_back(3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("s4_hold", {5'd0, V, A}, {5'd0, 1'b1, 2'd1});
    end
    do_ack();
    present();
    do_ack();

    // Set wins over clear in the same cycle
    pulse(4'b0100);
    exp_q.push_back(2);
    present();
    ack = 1'b1;
    D   = mk(4'b0100);
    E   = 1'b1;
    tick();
    ack = 1'b0;
    D   = 4'b0000;
    E   = 1'b0;
    check("s5_v", {7'd0, V}, 8'd0);
    check("s5_pend", {4'd0, as_mask(pend)}, 8'b0100);
    check("s5_ovr", {7'd0, ovr}, 8'd0);
    exp_q.push_back(2);
    present();
    do_ack();
    check("s5_pend0", {4'd0, as_mask(pend)}, 8'd0);

    // Overrun and asynchronous reset in HOLD
    pulse(4'b0001);
    exp_q.push_back(0);
    pulse(4'b0011);
    check("s6_ovr", {7'd0, ovr}, 8'd1);
    present();
    for (int k = 0; k < 2; k++) begin
      tick();
      check("s6_ovr_sticky", {7'd0, ovr}, 8'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_pend", {4'd0, as_mask(pend)}, 8'd0);
    check("s6_rst_vao", {5'd0, V, A}, 8'd0);
    check("s6_rst_ovr", {7'd0, ovr}, 8'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("s6_post_v", {7'd0, V}, 8'd0);
    check("s6_post_pend", {4'd0, as_mask(pend)}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
